ahb2_slv_sram: RTL

- AHB2 (ARM IHI 0011A) slave responder backed by a flop-array word memory. Attaches behind the decoder/mux as the slave end of AHB2_SLV_INTF (slave modport signal set).
- Supports single and burst transfers with a programmable number of wait states.
- Issues the two-cycle ERROR response for illegal accesses. Never issues RETRY or SPLIT.

---
 rtl/ahb2_slv_sram.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb2_slv_sram.sv
// ---------------------------------------------------------------------------
// ahb2_slv_sram
//
// Purpose:
//   AHB2 slave responder backed by a flop-array word memory. It sits behind
//   the address decoder / response mux and serves single and burst
//   transfers. It can insert a fixed number of wait states per transfer and
//   answers illegal accesses with the two-cycle ERROR response. It never
//   issues RETRY or SPLIT.
//
// Parameters:
//   ADDR_WIDTH  - word-address bits; the memory holds 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES - wait states (hreadyo low, OKAY) before each transfer completes, 0..15
//
// Ports:
//   hclk      in   clock
//   hreset_n  in   asynchronous active-low reset
//   hsel      in   slave select from the decoder
//   haddr     in   byte address; only [ADDR_WIDTH+1:0] is decoded
//   htrans    in   IDLE / BUSY / NONSEQ / SEQ
//   hwrite    in   1 = write
//   hsize     in   0 = byte, 1 = half, 2 = word
//   hburst    in   burst type (not used for decode)
//   hprot     in   protection (used only with the write-protect option)
//   hwdata    in   write data, data phase
//   hreadyi   in   bus HREADY; the address phase is sampled only when high
//   hrdata    out  read data
//   hreadyo   out  this slave's HREADY
//   hresp     out  OKAY or ERROR
//
// Build option:
//   AHB2_SRAM_WPROT_EN - when defined, a write with hprot[1]=0 (user access)
//                        is answered with ERROR and leaves memory untouched.
//                        When undefined, hprot is ignored.
// ---------------------------------------------------------------------------
module ahb2_slv_sram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hreadyi,
  output logic [31:0] hrdata,
  output logic        hreadyo,
  output logic [1:0]  hresp
);

  localparam int         MemDepth  = 2 ** ADDR_WIDTH;
  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespError = 2'b01;
  localparam logic [3:0] WaitLoad  = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            waitCnt_q, waitCnt_d;
  logic [ADDR_WIDTH+1:0] dataAddr_q, dataAddr_d;
  logic                  dataWrite_q, dataWrite_d;
  logic [2:0]            dataSize_q, dataSize_d;

  logic [31:0]           mem_q [MemDepth];

  logic                  addrPhaseOpen;
  logic                  accept;
  logic                  misaligned;
  logic                  protViolation;
  logic                  illegal;
  state_t                apState;
  logic [3:0]            apWaitCnt;
  logic [ADDR_WIDTH-1:0] memIdx;
  logic [3:0]            byteEn;
  logic                  memWrite;
  logic                  unusedBits;

  // Upper address bits wrap (the decoder owns range checking); hburst is
  // informational only, and hprot matters only with the write-protect option.
  assign unusedBits = ^{haddr[31:ADDR_WIDTH+2], hburst, hprot};

  // The bus only offers a new address phase while our HREADY is high, which
  // is the case in IDLE, DATA and the second ERROR cycle. Gating on our own
  // state keeps a misbehaving hreadyi from corrupting a transfer in flight.
  assign addrPhaseOpen = (state_q == ST_IDLE) || (state_q == ST_DATA) ||
                         (state_q == ST_ERR2);
  assign accept        = addrPhaseOpen && hsel && hreadyi && htrans[1];

  assign misaligned = ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

`ifdef AHB2_SRAM_WPROT_EN
  assign protViolation = hwrite && !hprot[1];
`else
  assign protViolation = 1'b0;
`endif

  assign illegal = (hsize > 3'd2) || misaligned || protViolation;

  // Outcome of the address phase currently on the bus: where the FSM goes
  // after this edge and what the wait counter starts from.
  always_comb begin
    apState   = ST_IDLE;
    apWaitCnt = waitCnt_q;
    if (accept) begin
      if (illegal) begin
        apState = ST_ERR1;
      end else if (WAIT_CYCLES == 0) begin
        apState = ST_DATA;
      end else begin
        apState   = ST_WAIT;
        apWaitCnt = WaitLoad;
      end
    end
  end

  assign memIdx   = dataAddr_q[ADDR_WIDTH+1:2];
  assign memWrite = (state_q == ST_DATA) && dataWrite_q;

  // Little-endian lane selection. Illegal sizes never reach ST_DATA, so the
  // default only exists to keep the decode complete.
  always_comb begin
    byteEn = 4'b0000;
    case (dataSize_q)
      3'd0:    byteEn = 4'b0001 << dataAddr_q[1:0];
      3'd1:    byteEn = dataAddr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  // Next state, data-phase capture and the response outputs. Responses are
  // decoded from the state register only, so asserting reset drives them to
  // their idle values without waiting for a clock edge.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    dataAddr_d  = dataAddr_q;
    dataWrite_d = dataWrite_q;
    dataSize_d  = dataSize_q;
    hreadyo     = 1'b1;
    hresp       = RespOkay;
    hrdata      = 32'h0000_0000;

    if (accept) begin
      dataAddr_d  = haddr[ADDR_WIDTH+1:0];
      dataWrite_d = hwrite;
      dataSize_d  = hsize;
    end

    case (state_q)
      ST_IDLE: begin
        state_d   = apState;
        waitCnt_d = apWaitCnt;
      end
      ST_WAIT: begin
        hreadyo = 1'b0;
        if (waitCnt_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      ST_DATA: begin
        if (!dataWrite_q) begin
          hrdata = mem_q[memIdx];
        end
        state_d   = apState;
        waitCnt_d = apWaitCnt;
      end
      ST_ERR1: begin
        hreadyo = 1'b0;
        hresp   = RespError;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = RespError;
        state_d   = apState;
        waitCnt_d = apWaitCnt;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data-phase registers.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= ST_IDLE;
      waitCnt_q   <= 4'd0;
      dataAddr_q  <= '0;
      dataWrite_q <= 1'b0;
      dataSize_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      dataAddr_q  <= dataAddr_d;
      dataWrite_q <= dataWrite_d;
      dataSize_q  <= dataSize_d;
    end
  end

  // Memory array, deliberately not reset. The write commits on the edge that
  // ends ST_DATA; a reset during the data phase forces the state to IDLE
  // first, so a pending write is dropped.
  always_ff @(posedge hclk) begin
    if (memWrite) begin
      if (byteEn[0]) mem_q[memIdx][7:0]   <= hwdata[7:0];
      if (byteEn[1]) mem_q[memIdx][15:8]  <= hwdata[15:8];
      if (byteEn[2]) mem_q[memIdx][23:16] <= hwdata[23:16];
      if (byteEn[3]) mem_q[memIdx][31:24] <= hwdata[31:24];
    end
  end

endmodule
